// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: per-stage hold, bubble and flush controls,
// FPU occupancy tracking in EX, load-use detection, redirect qualification.
module hazard_ctrl #(
  parameter int unsigned REGFILE_LEN = 6,
  parameter int unsigned FPU_LATENCY = 4,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_stall,
  input  logic [REGFILE_LEN-1:0] id_rs1,
  input  logic [REGFILE_LEN-1:0] id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   ex_valid,
  input  logic                   ex_mem_read,
  input  logic                   ex_alu_fpu,
  input  logic [REGFILE_LEN-1:0] ex_rd,
  input  logic                   redirect_req,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   id_ex_stall,
  output logic                   ex_mem_stall,
  output logic                   mem_wb_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_flush,
  output logic                   redirect_en,
  output logic                   fpu_busy,
  output logic [CNT_WIDTH-1:0]   stall_count
);

  localparam int unsigned CW = (FPU_LATENCY > 2) ? $clog2(FPU_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FPU_LATENCY - 1);

  typedef enum logic {RUN, FPU_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          fpu_hold;
  logic          load_use;

  // cnt stays 0 in RUN, so the first cycle of an FPU op is the cnt==0 case
  assign fpu_hold = ex_valid & ex_alu_fpu & (FPU_LATENCY > 1) & (cnt != CNT_LAST);
  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign fpu_busy = (state == FPU_WAIT);

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    redirect_en  = 1'b0;
    if (!rst) begin
      if (ext_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end else if (fpu_hold) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (redirect_req) begin
        redirect_en  = 1'b1;
        if_id_flush  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      if (pc_stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (!ext_stall) begin
        if (fpu_hold) begin
          state <= FPU_WAIT;
          cnt   <= cnt + 1'b1;
        end else begin
          state <= RUN;
          cnt   <= '0;
        end
      end
    end
  end

endmodule
